fetch_pc_unit: RTL

- Program-counter and instruction-fetch stage at the front of the single-issue RISC-V datapath.
- Holds the PC and requests one instruction word per step from instruction memory over a ready handshake.
- Presents the fetched instruction to decode.
- Applies taken-branch redirects. The offset arrives as a signed word offset, already divided by 4, from the clocked ALU-source/branch-offset multiplexer.

---
 rtl/rv_pkg.sv | 14 +
 rtl/fetch_pc_unit_if.sv | 25 ++
 rtl/pc_next_calc.sv | 17 +
 rtl/fetch_pc_unit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and constants for the front-end fetch datapath.
package rv_pkg;

  localparam int unsigned      XLEN      = 32;
  localparam logic [XLEN-1:0]  PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory and decode handshake bundle of the fetch stage.
interface fetch_pc_unit_if import rv_pkg::*; #(
  parameter int unsigned ADDR_W = 6
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [XLEN-1:0]   imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
    input  imem_ready, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
    output imem_ready, imem_rdata, instr_ready
  );

endinterface

// File: rtl/pc_next_calc.sv
// Successor PC of the presented instruction: sequential step or word-offset redirect.
module pc_next_calc import rv_pkg::*; (
  input  logic [XLEN-1:0] base_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] next_pc_c
);

  // Offset is in words; both adds wrap modulo 2^32.
  always_comb begin
    next_pc_c = base_pc + PC_STEP;
    if (branch_taken) begin
      next_pc_c = base_pc + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction fetch, presenting one word at a time to decode.
module fetch_pc_unit import rv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 64,
  parameter int unsigned     ADDR_W     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_offset,
  fetch_pc_unit_if.master   bus,
  output logic              fault
);

  localparam int unsigned        IDX_W     = XLEN - 2;
  localparam logic [IDX_W-1:0]   IDX_LIMIT = IDX_W'(IMEM_WORDS);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic              fault_q, fault_d;

  logic [XLEN-1:0]   next_pc;
  logic [IDX_W-1:0]  launch_idx;
  logic              launch;

  pc_next_calc u_pc_next_calc (
    .base_pc       (pc_out_q),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc_c     (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    fault_d       = fault_q;
    launch        = 1'b0;
    launch_idx    = (state_q == HOLD) ? next_pc[XLEN-1:2] : pc_q[XLEN-1:2];

    unique case (state_q)
      FETCH: begin
        // No request outstanding only in the first cycle out of reset.
        if (!imem_req_q) begin
          launch = 1'b1;
        end else if (bus.imem_ready) begin
          instr_d       = bus.imem_rdata;
          pc_out_d      = pc_q;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready && !stall) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          launch        = 1'b1;
        end
      end
      HALT: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        fault_d       = 1'b1;
      end
      default: begin
        imem_req_d = 1'b0;
        state_d    = FETCH;
      end
    endcase

    // Range check happens at the point a fetch would be issued.
    if (launch) begin
      if (launch_idx >= IDX_LIMIT) begin
        state_d    = HALT;
        fault_d    = 1'b1;
        imem_req_d = 1'b0;
      end else begin
        state_d     = FETCH;
        imem_req_d  = 1'b1;
        imem_addr_d = launch_idx[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign fault           = fault_q;

endmodule
